// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic SPI mode-0 ADC frame engine feeding a 16-bit sample buffer.
//   clk, resetq (async, active-low); enable, sample_period[15:0], cmd[15:0] in;
//   adc_csn, adc_sclk, adc_mosi out / adc_miso in (SPI to ADC);
//   wr, store_data[15:0] (one-cycle write strobe + result); busy, overrun (sticky) status.
module adc_spi_sampler #(
  parameter int CLKDIV = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        enable,
  input  logic [15:0] sample_period,
  input  logic [15:0] cmd,
  output logic        adc_csn,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic        wr,
  output logic [15:0] store_data,
  output logic        busy,
  output logic        overrun
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;
  logic [1:0]  state;
  logic [15:0] cnt, sr, pm1;
  logic [7:0]  div;
  logic [3:0]  bitn;
  logic        m1, m2, start, div_end;
  // >= rather than == so a period shortened below the running count still wraps promptly
  assign pm1     = (sample_period == 16'd0) ? 16'd0 : sample_period - 16'd1;
  assign start   = enable && (cnt >= pm1);
  assign div_end = div == 8'(CLKDIV - 1);
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) cnt <= '0;
    else cnt <= (!enable || start) ? 16'd0 : cnt + 16'd1;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) overrun <= 1'b0;
    else overrun <= !enable ? 1'b0 : (overrun || (start && busy));
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) {m1, m2} <= 2'b00;
    else {m1, m2} <= {adc_miso, m1};
  // sr shifts cmd out of its MSB while miso bits enter at the LSB, so after 16 rises it holds the result
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      state      <= IDLE;
      div        <= '0;
      bitn       <= '0;
      sr         <= '0;
      adc_csn    <= 1'b1;
      adc_sclk   <= 1'b0;
      adc_mosi   <= 1'b0;
      wr         <= 1'b0;
      store_data <= '0;
      busy       <= 1'b0;
    end else begin
      wr  <= 1'b0;
      div <= (state == IDLE || div_end) ? 8'd0 : div + 8'd1;
      case (state)
        IDLE:
          if (start) begin
            sr       <= cmd;
            adc_mosi <= cmd[15];
            adc_csn  <= 1'b0;
            busy     <= 1'b1;
            bitn     <= '0;
            state    <= SETUP;
          end
        SETUP: state <= div_end ? SHIFT : SETUP;
        SHIFT:
          if (div_end) begin
            adc_sclk <= !adc_sclk;
            if (!adc_sclk) sr <= {sr[14:0], m2};
            else begin
              adc_mosi <= (bitn == 4'd15) ? 1'b0 : sr[15];
              bitn     <= bitn + 4'd1;
              state    <= (bitn == 4'd15) ? HOLD : SHIFT;
            end
          end
        HOLD:
          if (div_end) begin
            adc_csn    <= 1'b1;
            busy       <= 1'b0;
            wr         <= 1'b1;
            store_data <= sr;
            state      <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: scoreboard bench with an ADC slave model and a cycle-level frame schedule model.
module tb_adc_spi_sampler;
  localparam int D = 2;
  localparam int FRAME = 34 * D;
  logic clk = 0, resetq = 0, enable = 0, adc_miso = 0;
  logic [15:0] sample_period = 16'd100, cmd = '0;
  logic adc_csn, adc_sclk, adc_mosi, wr, busy, overrun;
  logic [15:0] store_data;
  adc_spi_sampler #(.CLKDIV(D)) dut (
    .clk(clk), .resetq(resetq), .enable(enable), .sample_period(sample_period), .cmd(cmd),
    .adc_csn(adc_csn), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso),
    .wr(wr), .store_data(store_data), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_total = 0, cyc = 0;
  int efall[$], ewr[$];
  logic [15:0] edata[$];
  int ov_on = 32'h7fffffff, ov_off = 0;
  int rises = 0, idx = 0, low_len = 0;
  logic [15:0] mosi_w = '0, exp_cmd = '0, word = '0, last_sd = '0;
  logic prev_csn = 1, prev_sclk = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask
  // Frame schedule from the timer rules: start pulses at relative cycles p-1, 2p-1, ...;
  // a pulse is taken only once the previous frame's wr cycle has been reached, otherwise it flags overrun.
  task automatic model(input int c0, input int p, input int h);
    int pe = (p < 1) ? 1 : p;
    int free = 0;
    ov_on = 32'h7fffffff;
    for (int x = pe - 1; x < h; x += pe)
      if (x >= free) begin
        efall.push_back(c0 + x + 1);
        ewr.push_back(c0 + x + 1 + FRAME);
        free = x + 1 + FRAME;
      end else if (ov_on > c0 + x + 1) ov_on = c0 + x + 1;
    ov_off = c0 + h + 1;
  endtask
  task automatic drain();
    for (int k = 0; k < 400 && ewr.size() != 0; k++) @(negedge clk);
    chk("wr_drain", ewr.size(), 0);
    chk("start_drain", efall.size(), 0);
    efall.delete(); ewr.delete(); edata.delete();
    repeat (10) @(negedge clk);
  endtask
  task automatic run(input int p, input int h);
    @(negedge clk);
    sample_period = p[15:0];
    model(cyc, p, h);
    enable = 1;
    repeat (h) @(negedge clk);
    enable = 0;
    drain();
  endtask
  always @(negedge clk) cmd = 16'($urandom);
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!resetq) begin
      chk("reset_ctl", {adc_csn, adc_sclk, adc_mosi, wr, busy, overrun}, 6'b100000);
      chk("reset_data", store_data, 0);
      prev_csn = 1; prev_sclk = 0; last_sd = '0; adc_miso = 0;
    end else begin
      if (prev_csn && !adc_csn) begin
        chk("start_expected", efall.size() != 0, 1);
        if (efall.size() != 0) chk("start_cycle", cyc, efall.pop_front());
        word = 16'($urandom);
        edata.push_back(word);
        exp_cmd = cmd;
        adc_miso = word[15];
        idx = 14; rises = 0; mosi_w = '0; low_len = 0;
      end
      if (!adc_csn) begin
        low_len++;
        if (adc_sclk && !prev_sclk) begin
          rises++;
          mosi_w = {mosi_w[14:0], adc_mosi};
          if (idx >= 0) begin adc_miso = word[idx]; idx--; end
        end
      end else chk("sclk_idle", adc_sclk, 0);
      if (!prev_csn && adc_csn) begin
        chk("csn_low_cycles", low_len, FRAME);
        chk("sclk_rises", rises, 16);
        chk("mosi_word", mosi_w, exp_cmd);
        chk("wr_at_csn_rise", wr, 1);
      end
      if (wr) begin
        chk("wr_expected", ewr.size() != 0, 1);
        if (ewr.size() != 0) chk("wr_cycle", cyc, ewr.pop_front());
        if (edata.size() != 0) chk("store_data", store_data, edata.pop_front());
        last_sd = store_data;
      end else chk("store_data_hold", store_data, last_sd);
      chk("overrun", overrun, (cyc >= ov_on && cyc < ov_off));
      chk("busy", busy, !adc_csn);
      prev_csn = adc_csn;
      prev_sclk = adc_sclk;
    end
  end
  initial begin
    int p, h;
    repeat (5) @(negedge clk);
    resetq = 1;
    repeat (3) @(negedge clk);
    run(100, 150);
    run(100, 500);
    run(40, 400);
    run(0, 150);
    repeat (3) begin
      p = $urandom_range(20, 200);
      h = $urandom_range(150, 500);
      run(p, h);
    end
    @(negedge clk);
    sample_period = 16'd60;
    model(cyc, 60, 70);
    enable = 1;
    for (int k = 0; k < 300 && !(rises == 8 && adc_sclk && !adc_csn); k++) @(negedge clk);
    chk("reach_bit7", rises, 8);
    #2 resetq = 0;
    #1;
    chk("async_csn", adc_csn, 1);
    chk("async_sclk", adc_sclk, 0);
    chk("async_mosi", adc_mosi, 0);
    chk("async_wr", wr, 0);
    chk("async_busy", busy, 0);
    chk("async_overrun", overrun, 0);
    chk("async_data", store_data, 0);
    repeat (3) @(negedge clk);
    efall.delete(); ewr.delete(); edata.delete();
    model(cyc, 60, 200);
    resetq = 1;
    repeat (200) @(negedge clk);
    enable = 0;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Upstream producer for the 16-bit sample ring buffer.
- Periodically runs one SPI mode-0 frame to an external ADC: shifts out a 16-bit command word and shifts in a 16-bit result.
- Presents each result on `store_data` with a one-cycle `wr` strobe, ready to wire directly to the buffer's write side.
- Includes a programmable sample-rate timer and a sticky overrun flag.

Parameters:
- CLKDIV, default 4: clk cycles per SCLK half-period. Legal range is 1..255.

Ports:
- clk  input  1  system clock.
- resetq  input  1  reset, asynchronous, active-low.
- enable  input  1  run the sample timer. When low, no new frames start.
- sample_period  input  16  clk cycles between frame starts. A value of 0 behaves as 1.
- cmd  input  16  ADC command word, latched at frame start.
- adc_csn  output  1  ADC chip select, active-low.
- adc_sclk  output  1  SPI clock, idle low.
- adc_mosi  output  1  command data, MSB first.
- adc_miso  input  1  result data, MSB first. Synchronised internally by a 2-flop synchroniser.
- wr  output  1  one-cycle strobe: `store_data` is valid.
- store_data  output  16  last completed result.
- busy  output  1  frame in progress.
- overrun  output  1  sticky: a timer start was dropped because a frame was already in progress.

Behaviour:
- Reset (asynchronous, `resetq` low), applies immediately, including mid-frame:
  - `adc_csn`=1, `adc_sclk`=0, `adc_mosi`=0, `wr`=0, `store_data`=0, `busy`=0, `overrun`=0.
  - Timer=0, state=IDLE.
  - A partial frame is abandoned and produces no `wr`.
- Timer:
  - Counts 0..sample_period-1 while `enable`=1.
  - A start pulse is generated in the cycle the count equals sample_period-1, and the count wraps to 0.
  - `enable`=0 holds the timer at 0. A frame already running completes normally and produces its `wr`.
  - With `enable` rising at cycle 0, the first start is at cycle sample_period-1.
  - `adc_csn` falls on the following edge.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
  - IDLE:
    - `csn`=1, `busy`=0.
    - On start: latch `cmd`, drive `mosi`=cmd[15], `csn`=0, `busy`=1, go to SETUP.
  - SETUP:
    - Lasts CLKDIV cycles with `sclk`=0, then go to SHIFT.
  - SHIFT, 16 bits, each bit 2*CLKDIV cycles:
    - `sclk` is low for CLKDIV cycles, then high for CLKDIV cycles.
    - The synchronised `miso` bit is captured into the shift register on the clk edge where `sclk` goes high. MSB arrives first.
    - `mosi` advances to the next cmd bit on the edge where `sclk` returns low.
    - After bit 15's high phase, go to HOLD.
  - HOLD:
    - Lasts CLKDIV cycles with `sclk`=0, `csn`=0.
    - On its final edge: `csn`=1, `busy`=0, `wr`=1 for exactly one cycle, `store_data`=shift register, go to IDLE.
- Frame timing:
  - `csn` is low for exactly 34*CLKDIV cycles.
  - `wr` is high in the first cycle with `csn` high.
  - The next start is earliest on the following cycle, so `csn` high time ≥1 cycle.
- `store_data` holds its value until the next `wr`. It never changes outside a `wr` cycle.
- MISO latency: the 2-flop synchroniser delays samples by 2 clk cycles. The external ADC must present data with ≥2 cycles of margin before the SCLK rise; with CLKDIV ≥3 this is guaranteed for data changing on the SCLK fall.
- Overrun:
  - A start while `busy`=1 is dropped and sets `overrun`=1.
  - The timer continues without resynchronising.
  - `overrun` clears only on reset or while `enable`=0.
- Changes to `cmd` mid-frame do not affect the current frame.
- Changes to `sample_period` take effect at the next timer compare.
- Downstream contract: `wr` asserts at most once per 34*CLKDIV+1 cycles. There is no backpressure; the consumer must keep up.

Test Plan:
- Reset: hold `resetq`=0, toggle clk -> `csn`=1, `sclk`=0, `mosi`=0, `wr`=0, `store_data`=0x0000, `busy`=0, `overrun`=0.
- Single frame, CLKDIV=2, sample_period=100, cmd=0x1234, ADC model returns 0xA5C3, `enable` rises at cycle 0:
  - `csn` falls at cycle 100.
  - Exactly 16 `sclk` rising edges.
  - `mosi` bits observed at those edges read 0x1234.
  - `csn` rises at cycle 168 with `wr`=1 for one cycle and `store_data`=0xA5C3.
- Periodic run, sample_period=100, 5 frames:
  - `wr` strobes exactly 100 cycles apart.
  - `overrun` stays 0.
  - Connected buffer's valid rises after each `wr`; reading returns values in order.
- Overrun, CLKDIV=2, sample_period=40 (frame is 68 cycles):
  - Every second start is dropped.
  - `overrun`=1 after the first drop.
  - `wr` interval is 80 cycles.
  - Dropping `enable` clears `overrun`.
- `enable` falls mid-SHIFT -> current frame completes with one `wr`; no further `csn` fall while `enable`=0.
- Reset mid-SHIFT (bit 7):
  - Outputs return to reset values immediately, asynchronously and without a clk edge.
  - No `wr` occurs.
  - After release with `enable`=1, the next frame starts sample_period cycles later and returns correct data.
